// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter:
// parity-mode encodings and the transmit FSM state type.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE  = 2'b00;
  localparam logic [1:0] PARITY_EVEN  = 2'b01;
  localparam logic [1:0] PARITY_ODD   = 2'b10;
  localparam logic [1:0] PARITY_NONE2 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Both 00 and 11 mean "no parity bit".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are ignored. DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // A simultaneous push and pop leaves the level untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a small FIFO. Line settings are captured when a
// byte is popped, so each frame keeps the divisor/parity/stop it started with.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_e             state;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [DIV_WIDTH-1:0]  div_l;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic                  stop2_l;
  logic                  par_en;
  logic                  par_bit;
  logic [DATA_BITS-1:0]  shreg;
  logic [DATA_BITS-1:0]  pop_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  bit_end;
  logic                  last_stop;

  assign wr_ready  = !fifo_full;
  assign bit_end   = (baud_cnt == div_l);
  assign last_stop = (stop_cnt == stop2_l);
  assign pop       = !fifo_empty &&
                     ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid && wr_ready),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // tx_done is registered, so it is raised one edge ahead of the final
  // stop-bit cycle; with a zero divisor that edge is the entry into that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      div_l    <= '0;
      stop2_l  <= 1'b0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      shreg    <= '0;
    end else begin
      tx_done <= 1'b0;
      if (pop) begin
        state    <= START;
        tx       <= 1'b0;
        busy     <= 1'b1;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        shreg    <= pop_data;
        div_l    <= divisor;
        stop2_l  <= stop2;
        par_en   <= parity_enabled(parity_mode);
        par_bit  <= (^pop_data) ^ (parity_mode == PARITY_ODD);
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              state    <= DATA;
              tx       <= shreg[0];
              baud_cnt <= '0;
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_cnt == LAST_BIT) begin
                if (par_en) begin
                  state <= PARITY;
                  tx    <= par_bit;
                end else begin
                  state   <= STOP;
                  tx      <= 1'b1;
                  tx_done <= (div_l == '0) && !stop2_l;
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                shreg   <= shreg >> 1;
                tx      <= shreg[1];
              end
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
          PARITY: begin
            if (bit_end) begin
              state    <= STOP;
              tx       <= 1'b1;
              baud_cnt <= '0;
              tx_done  <= (div_l == '0) && !stop2_l;
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
          end
          STOP: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (!last_stop) begin
                stop_cnt <= 1'b1;
                tx_done  <= (div_l == '0);
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
              tx_done  <= last_stop && ((baud_cnt + DIV_WIDTH'(1)) == div_l);
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed and randomized frames
// compared cycle by cycle against a bit-list reference model.
module tb_uart_tx_buffered;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_WIDTH  = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DIV_WIDTH-1:0] divisor;
  logic [1:0]           parity_mode;
  logic                 stop2;
  logic                 wr_valid;
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_ready;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;
  logic [LW-1:0]        fifo_level;

  int checks = 0;
  int errors = 0;

  logic exp_tx[$];
  logic exp_done[$];

  uart_tx_buffered #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_WIDTH  (DIV_WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .divisor     (divisor),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  // Appends one frame to the expected line trace: each bit held div+1 cycles,
  // tx_done only on the very last cycle of the frame.
  function automatic void model_frame(input logic [DATA_BITS-1:0] d, input int div,
                                      input logic [1:0] pm, input logic s2);
    logic bits[$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pm == 2'b01) bits.push_back(1'(ones % 2));
    if (pm == 2'b10) bits.push_back(1'(1 - (ones % 2)));
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int j = 0; j < bits.size(); j++) begin
      for (int r = 0; r <= div; r++) begin
        exp_tx.push_back(bits[j]);
        exp_done.push_back((j == bits.size() - 1) && (r == div));
      end
    end
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    divisor = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (tx !== 1'b1)        begin errors++; $display("[TB] FAIL reset_tx got %b want 1", tx); end
    if (wr_ready !== 1'b1)  begin errors++; $display("[TB] FAIL reset_wr_ready got %b want 1", wr_ready); end
    if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    if (tx_done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_tx_done got %b want 0", tx_done); end
    if (fifo_level !== '0)  begin errors++; $display("[TB] FAIL reset_level got %0d want 0", fifo_level); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, busy, tx_done} !== 3'b100)
      begin errors++; $display("[TB] FAIL reset_release got %b want 100", {tx, busy, tx_done}); end
  endtask

  task automatic test_frame_a5();
    logic [10:0] pat;
    int done_cnt;
    int done_at;
    $display("[TB] test_frame_a5");
    pat = {1'b1, 1'b0, 8'hA5, 1'b0};
    done_cnt = 0; done_at = -1;
    divisor = 16'd3; parity_mode = 2'b01; stop2 = 1'b0;
    for (int s = 1; s <= 50; s++) begin
      wr_valid = (s == 1);
      wr_data  = 8'hA5;
      @(negedge clk);
      if (s >= 2 && s <= 45) begin
        checks++;
        if (tx !== pat[(s - 2) / 4])
          begin errors++; $display("[TB] FAIL a5_tx cycle %0d got %b want %b", s - 1, tx, pat[(s - 2) / 4]); end
      end
      if (s == 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL a5_busy_start got %b want 1", busy); end
      end
      if (s == 46) begin
        checks++;
        if ({tx, busy} !== 2'b10) begin errors++; $display("[TB] FAIL a5_idle got %b want 10", {tx, busy}); end
      end
      if (tx_done === 1'b1) begin done_cnt++; done_at = s - 1; end
    end
    checks += 2;
    if (done_cnt != 1) begin errors++; $display("[TB] FAIL a5_done_count got %0d want 1", done_cnt); end
    if (done_at != 44) begin errors++; $display("[TB] FAIL a5_done_cycle got %0d want 44", done_at); end
  endtask

  task automatic test_odd_two_stop();
    logic [2:0] exp;
    int k;
    int done_cnt;
    logic par_obs;
    $display("[TB] test_odd_two_stop");
    exp_tx.delete(); exp_done.delete();
    model_frame(8'h00, 1, 2'b10, 1'b1);
    done_cnt = 0; par_obs = 1'bx;
    divisor = 16'd1; parity_mode = 2'b10; stop2 = 1'b1;
    for (int s = 1; s <= exp_tx.size() + 5; s++) begin
      wr_valid = (s == 1);
      wr_data  = 8'h00;
      @(negedge clk);
      k = s - 2;
      if (k >= 0 && k < exp_tx.size()) exp = {exp_tx[k], exp_done[k], 1'b1};
      else exp = 3'b100;
      checks++;
      if ({tx, tx_done, busy} !== exp)
        begin errors++; $display("[TB] FAIL odd2_line k=%0d got %b want %b", k, {tx, tx_done, busy}, exp); end
      if (k == 18) par_obs = tx;
      if (tx_done === 1'b1) done_cnt++;
    end
    checks += 2;
    if (par_obs !== 1'b1) begin errors++; $display("[TB] FAIL odd2_parity got %b want 1", par_obs); end
    if (done_cnt != 1)    begin errors++; $display("[TB] FAIL odd2_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_BITS-1:0] bytes[$];
    logic [2:0] exp;
    int k, div, n;
    logic [1:0] pm;
    logic s2;
    $display("[TB] test_back_to_back");
    for (int it = 0; it < 6; it++) begin
      div = (it == 0) ? 0 : (it == 1) ? 2 : int'($urandom_range(4));
      pm  = (it == 1) ? 2'b00 : 2'($urandom_range(3));
      s2  = (it == 1) ? 1'b0 : 1'($urandom_range(1));
      n   = (it == 1) ? 2 : int'($urandom_range(5, 2));
      bytes.delete(); exp_tx.delete(); exp_done.delete();
      for (int b = 0; b < n; b++) begin
        bytes.push_back(DATA_BITS'($urandom));
        model_frame(bytes[b], div, pm, s2);
      end
      divisor = DIV_WIDTH'(div); parity_mode = pm; stop2 = s2;
      for (int s = 1; s <= exp_tx.size() + 5; s++) begin
        if (s <= n) begin wr_valid = 1'b1; wr_data = bytes[s - 1]; end
        else wr_valid = 1'b0;
        @(negedge clk);
        k = s - 2;
        if (k >= 0 && k < exp_tx.size()) exp = {exp_tx[k], exp_done[k], 1'b1};
        else exp = 3'b100;
        checks++;
        if ({tx, tx_done, busy} !== exp)
          begin errors++; $display("[TB] FAIL b2b_line it=%0d k=%0d got %b want %b", it, k, {tx, tx_done, busy}, exp); end
      end
    end
  endtask

  task automatic test_divisor_change();
    logic [DATA_BITS-1:0] b0, b1;
    logic [2:0] exp;
    int k;
    $display("[TB] test_divisor_change");
    b0 = DATA_BITS'($urandom); b1 = DATA_BITS'($urandom);
    exp_tx.delete(); exp_done.delete();
    model_frame(b0, 3, 2'b00, 1'b0);
    model_frame(b1, 7, 2'b00, 1'b0);
    divisor = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    for (int s = 1; s <= exp_tx.size() + 5; s++) begin
      wr_valid = (s <= 2);
      wr_data  = (s == 1) ? b0 : b1;
      if (s == 6) divisor = 16'd7;
      @(negedge clk);
      k = s - 2;
      if (k >= 0 && k < exp_tx.size()) exp = {exp_tx[k], exp_done[k], 1'b1};
      else exp = 3'b100;
      checks++;
      if ({tx, tx_done, busy} !== exp)
        begin errors++; $display("[TB] FAIL divchg_line k=%0d got %b want %b", k, {tx, tx_done, busy}, exp); end
    end
  endtask

  task automatic test_fifo_full();
    int lvl_exp[10];
    int ready_at;
    int done_at;
    $display("[TB] test_fifo_full");
    lvl_exp = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};
    divisor = 16'd100; parity_mode = 2'b00; stop2 = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      wr_valid = 1'b1;
      wr_data  = DATA_BITS'($urandom);
      @(negedge clk);
      checks++;
      if (fifo_level !== LW'(lvl_exp[s - 1]))
        begin errors++; $display("[TB] FAIL full_level s=%0d got %0d want %0d", s, fifo_level, lvl_exp[s - 1]); end
      if (s == 2) begin
        checks++;
        if ({tx, busy} !== 2'b01) begin errors++; $display("[TB] FAIL full_first_pop got %b want 01", {tx, busy}); end
      end
      if (s >= 9) begin
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_wr_ready s=%0d got %b want 0", s, wr_ready); end
      end
    end
    ready_at = -1; done_at = -1;
    for (int s = 11; s <= 1200 && ready_at < 0; s++) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_at = s;
      if (wr_ready === 1'b1) ready_at = s;
    end
    checks += 3;
    if (ready_at < 0) begin errors++; $display("[TB] FAIL full_timeout got no wr_ready want it at 1012"); end
    else if (ready_at != 1012) begin errors++; $display("[TB] FAIL full_ready_time got %0d want 1012", ready_at); end
    if (done_at != 1011) begin errors++; $display("[TB] FAIL full_done_time got %0d want 1011", done_at); end
    if (fifo_level !== LW'(7)) begin errors++; $display("[TB] FAIL full_level_after_pop got %0d want 7", fifo_level); end
    @(negedge clk);
    wr_valid = 1'b0;
    checks += 2;
    if (fifo_level !== LW'(8)) begin errors++; $display("[TB] FAIL full_tenth_accept got %0d want 8", fifo_level); end
    if (wr_ready !== 1'b0)     begin errors++; $display("[TB] FAIL full_ready_again got %b want 0", wr_ready); end
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    int done_seen;
    int tx_low;
    $display("[TB] test_reset_mid_frame");
    divisor = 16'd3; parity_mode = 2'b00; stop2 = 1'b0;
    for (int s = 1; s <= 19; s++) begin
      wr_valid = (s <= 4);
      wr_data  = DATA_BITS'($urandom);
      @(negedge clk);
    end
    checks += 2;
    if (fifo_level !== LW'(3)) begin errors++; $display("[TB] FAIL midrst_pre_level got %0d want 3", fifo_level); end
    if (busy !== 1'b1)         begin errors++; $display("[TB] FAIL midrst_pre_busy got %b want 1", busy); end
    rst = 1'b1; wr_valid = 1'b0;
    @(negedge clk);
    checks += 4;
    if (tx !== 1'b1)       begin errors++; $display("[TB] FAIL midrst_tx got %b want 1", tx); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
    if (fifo_level !== '0) begin errors++; $display("[TB] FAIL midrst_level got %0d want 0", fifo_level); end
    if (tx_done !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_done got %b want 0", tx_done); end
    rst = 1'b0;
    done_seen = 0; tx_low = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen++;
      if (tx !== 1'b1) tx_low++;
    end
    checks += 2;
    if (done_seen != 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d want 0", done_seen); end
    if (tx_low != 0)    begin errors++; $display("[TB] FAIL midrst_line_idle got %0d low cycles want 0", tx_low); end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_odd_two_stop();
    test_back_to_back();
    test_divisor_change();
    test_fifo_full();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
